mips_mc_controller: RTL and testbench

Multicycle successor to the single-cycle MIPS control path. A Moore-style FSM with Mealy-qualified memory strobes sequences each instruction over 3-5+ cycles through one shared ALU and one unified memory. It stalls on a ready/valid memory handshake and adds bne/addi/jal support. It also maintains a retired-instruction counter. It sits beside the multicycle datapath in the core top and replaces the combinational control path.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_mc_decode.sv | 117 +++++++++++
 rtl/mips_mc_controller.sv | 133 +++++++++++++
 tb/tb_mips_mc_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control path.
//   - opcode constants (IR[31:26])
//   - 4-bit FSM state enumeration (its values are exported on state_dbg)
//   - datapath selector encodings for alu_src_b, pc_source and alu_op
//   - op_legal(): whether an opcode is recognised by this build
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_legal(input logic [5:0] op, input logic en_jal);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: ok = 1'b1;
      OP_JAL: ok = en_jal;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational state -> datapath strobe decoder.
// Outputs are a function of the current state; the only input qualifiers
// are mem_rdy (FETCH commit), zero/opcode (branch decision) and opcode
// (illegal detection in DECODE).
// Ports:
//   state      in   current FSM state
//   opcode     in   IR[31:26]
//   zero       in   ALU zero flag
//   mem_rdy    in   effective memory-ready (already masked by handshake mode)
//   pc_en .. illegal_op  out  control strobes to the multicycle datapath
module mips_mc_decode
  import mips_pkg::*;
#(
  parameter int EN_JAL = 1
) (
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_en,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        jal,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op
);

  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    jal        = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 commit only in the cycle the memory returns data.
        ir_write  = mem_rdy;
        pc_en     = mem_rdy;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !op_legal(opcode, EN_JAL != 0);
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = (opcode == OP_BNE) ? !zero : zero;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH; that value is written to $31.
        jal       = 1'b1;
        reg_write = 1'b1;
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM with retired counter.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | after reset, all strobes low
// FETCH      | read IR at PC, PC <= PC+4 on mem_ready
// DECODE     | dispatch on opcode, branch target -> ALUOut
// MEMADR     | compute A + imm for lw/sw
// MEMRD      | load data read, waits for mem_ready
// MEM_WB     | write MDR to rt
// MEMWR      | store write, waits for mem_ready
// RTYPE_EX   | A op B using funct
// RTYPE_WB   | write ALUOut to rd
// BRANCH     | compare A-B, load PC from ALUOut if taken
// ADDI_EX    | A + imm
// ADDI_WB    | write ALUOut to rt
// JUMP       | PC <= jump target
// JAL        | $31 <= PC, PC <= jump target
//
// Ports:
//   clk, reset (async, active low)
//   opcode, zero, mem_ready         in   from datapath / memory
//   pc_en .. pc_source, illegal_op  out  datapath control
//   retired                         out  completed-instruction count (wraps)
//   state_dbg                       out  current state encoding
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int RETIRE_W      = 32,
  parameter int EN_JAL        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                jal,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  state_t state, state_nxt;
  logic   mem_rdy;
  logic   retire_now;

  assign mem_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: state_nxt = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_nxt = S_RTYPE_EX;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_ADDI:       state_nxt = S_ADDI_EX;
          OP_J:          state_nxt = S_JUMP;
          OP_JAL:        state_nxt = (EN_JAL != 0) ? S_JAL : S_FETCH;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_nxt = mem_rdy ? S_MEM_WB : S_MEMRD;
      S_MEMWR:    state_nxt = mem_rdy ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_nxt = S_RTYPE_WB;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      S_MEM_WB, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP, S_JAL:
        state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    retire_now = 1'b0;
    case (state)
      S_RTYPE_WB, S_MEM_WB, S_BRANCH, S_ADDI_WB, S_JUMP, S_JAL:
        retire_now = 1'b1;
      S_MEMWR: retire_now = mem_rdy;
      default: retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          retired <= '0;
    else if (retire_now) retired <= retired + RETIRE_W'(1);
  end

  mips_mc_decode #(
    .EN_JAL (EN_JAL)
  ) u_decode (
    .state      (state),
    .opcode     (opcode),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .jal        (jal),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller. Two instances share stimulus:
// u_dut uses default parameters; u_alt has MEM_HANDSHAKE=0, RETIRE_W=4,
// EN_JAL=0 and is only checked after a common reset.
module tb_mips_mc_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic zero;
  logic mem_ready;

  logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, jal, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [31:0] retired;
  logic [3:0] st;

  logic a_pc_en, a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_reg_dst;
  logic a_mem_to_reg, a_reg_write, a_jal, a_alu_src_a, a_illegal_op;
  logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
  logic [3:0] a_retired;
  logic [3:0] a_st;

  int n_checks = 0;
  int n_errors = 0;
  int ir_cnt = 0;
  int ir_base;

  localparam logic [9:0] LW_MR = 10'b1100011100;
  localparam logic [3:0] LW_ST [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3,
                                        4'd4, 4'd4, 4'd4, 4'd4, 4'd5};

  always #5 clk = ~clk;

  mips_mc_controller u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .retired(retired), .state_dbg(st)
  );

  mips_mc_controller #(.MEM_HANDSHAKE(0), .RETIRE_W(4), .EN_JAL(0)) u_alt (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(a_pc_en), .i_or_d(a_i_or_d),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .jal(a_jal), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .pc_source(a_pc_source), .illegal_op(a_illegal_op),
    .retired(a_retired), .state_dbg(a_st)
  );

  always @(posedge clk) if (ir_write) ir_cnt <= ir_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; opcode = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(st), 32'(S_IDLE));
    chk("rst_retired", retired, 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write, reg_write, pc_en, ir_write}), 32'd0);

    reset = 1'b1; #1;
    chk("idle_hold", 32'(st), 32'(S_IDLE));

    // add: FETCH, DECODE, RTYPE_EX, RTYPE_WB
    step();
    chk("add_fetch", 32'(st), 32'(S_FETCH));
    chk("add_fetch_rd", 32'(mem_read), 32'd1);
    chk("add_fetch_irw", 32'(ir_write), 32'd1);
    chk("add_fetch_srcb", 32'(alu_src_b), 32'd1);
    step();
    chk("add_decode", 32'(st), 32'(S_DECODE));
    chk("add_decode_srcb", 32'(alu_src_b), 32'd3);
    step();
    chk("add_ex", 32'(st), 32'(S_RTYPE_EX));
    chk("add_ex_aluop", 32'(alu_op), 32'd2);
    chk("add_ex_srca", 32'(alu_src_a), 32'd1);
    step();
    chk("add_wb_rw", 32'(reg_write), 32'd1);
    chk("add_wb_dst", 32'(reg_dst), 32'd1);
    chk("add_wb_ret", retired, 32'd0);
    step();
    chk("add_ret", retired, 32'd1);
    chk("add_back_fetch", 32'(st), 32'(S_FETCH));

    // lw with 2 wait cycles in FETCH and 3 in MEMRD: 10 cycles
    opcode = OP_LW;
    ir_base = ir_cnt;
    for (int i = 0; i < 10; i++) begin
      mem_ready = LW_MR[i];
      #1;
      chk("lw_state", 32'(st), 32'(LW_ST[i]));
      chk("lw_mem_read", 32'(mem_read), 32'((LW_ST[i] == 4'd1) || (LW_ST[i] == 4'd4)));
      chk("lw_ir_write", 32'(ir_write), 32'(i == 2));
      step();
    end
    chk("lw_done_state", 32'(st), 32'(S_FETCH));
    chk("lw_ret", retired, 32'd2);
    chk("lw_ir_pulses", 32'(ir_cnt - ir_base), 32'd1);

    // beq taken
    mem_ready = 1'b1; opcode = OP_BEQ; zero = 1'b1;
    step(); step();
    chk("beq_state", 32'(st), 32'(S_BRANCH));
    chk("beq_pc_en", 32'(pc_en), 32'd1);
    chk("beq_pcsrc", 32'(pc_source), 32'd1);
    chk("beq_aluop", 32'(alu_op), 32'd1);
    step();
    chk("beq_ret", retired, 32'd3);

    // bne with zero=1 not taken, zero=0 taken
    opcode = OP_BNE;
    step(); step();
    chk("bne_state", 32'(st), 32'(S_BRANCH));
    chk("bne_z1_pc_en", 32'(pc_en), 32'd0);
    zero = 1'b0; #1;
    chk("bne_z0_pc_en", 32'(pc_en), 32'd1);
    step();
    chk("bne_ret", retired, 32'd4);

    // illegal opcode
    opcode = 6'b111111;
    step();
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    step();
    chk("ill_clear", 32'(illegal_op), 32'd0);
    chk("ill_state", 32'(st), 32'(S_FETCH));
    chk("ill_ret", retired, 32'd4);

    // jal
    opcode = OP_JAL;
    step(); step();
    chk("jal_state", 32'(st), 32'(S_JAL));
    chk("jal_strobes", 32'({jal, reg_write, pc_en}), 32'h7);
    chk("jal_pcsrc", 32'(pc_source), 32'd2);
    step();
    chk("jal_ret", retired, 32'd5);

    // sw, reset during the MEMWR wait
    opcode = OP_SW;
    step(); step();
    chk("sw_memadr_srcb", 32'(alu_src_b), 32'd2);
    mem_ready = 1'b0;
    step();
    chk("sw_memwr", 32'(mem_write), 32'd1);
    chk("sw_no_read", 32'(mem_read), 32'd0);
    step();
    chk("sw_wait_hold", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b0; #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_state", 32'(st), 32'(S_IDLE));
    chk("abort_ret", retired, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    opcode = OP_JAL;
    step();
    chk("resume_fetch", 32'(st), 32'(S_FETCH));
    chk("main_wait_pc_en", 32'(pc_en), 32'd0);

    // alt instance: handshake ignored, jal illegal, 4-bit retired counter
    chk("alt_fetch_pc_en", 32'(a_pc_en), 32'd1);
    step();
    chk("alt_jal_illegal", 32'(a_illegal_op), 32'd1);
    step();
    chk("alt_ill_state", 32'(a_st), 32'(S_FETCH));
    chk("alt_ill_ret", 32'(a_retired), 32'd0);
    opcode = OP_J;
    for (int j = 0; j < 17 * 3; j++) step();
    chk("alt_wrap_ret", 32'(a_retired), 32'd1);
    chk("alt_wrap_state", 32'(a_st), 32'(S_FETCH));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
